rst_sequencer: RTL and testbench

Parametrised multi-domain reset sequencer: the successor to the single-counter reset generator in the clock infrastructure. It qualifies the MMCM/PLL lock with a hold time, then releases N_RST reset domains one at a time with a programmable gap. Selected domains are also gated on IDELAYCTRL ready. It monitors lock after release, re-asserts every domain on filtered loss of lock or a soft-reset request, and counts lock-loss events. It sits beside the clock generator, driving every per-domain reset in the design.

---
 rtl/rst_sequencer.sv | 176 +++++++++++++++++
 tb/tb_rst_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// Multi-domain reset sequencer: qualifies PLL lock with a hold time, then releases
// reset domains one at a time, re-asserting all of them on filtered lock loss or soft reset.
module rst_sequencer #(
    parameter int               N_RST       = 4,
    parameter int               HOLD_CYCLES = 65535,
    parameter int               STAGE_GAP   = 16,
    parameter int               LOCK_FILT   = 4,
    parameter logic [N_RST-1:0] RDY_MASK    = '0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pll_lock,
    input  logic             idelay_rdy,
    input  logic             soft_rst,
    output logic [N_RST-1:0] rst_out,
    output logic             all_rdy,
    output logic [1:0]       seq_state,
    output logic [7:0]       lock_loss_cnt
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int FILT_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam int IDX_W  = (N_RST > 1) ? $clog2(N_RST) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_RST - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Bit 0 carries pll_lock, bit 1 carries idelay_rdy through identical 2-FF synchronisers.
    logic [1:0] async_in;
    logic [1:0] sync_vec;
    logic       lock_s;
    logic       rdy_s;

    assign async_in = {idelay_rdy, pll_lock};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic meta_reg;
        logic sync_reg;

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                meta_reg <= 1'b0;
                sync_reg <= 1'b0;
            end else begin
                meta_reg <= async_in[gi];
                sync_reg <= meta_reg;
            end
        end

        assign sync_vec[gi] = sync_reg;
    end

    assign lock_s = sync_vec[0];
    assign rdy_s  = sync_vec[1];

    state_t            state_reg,    state_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [GAP_W-1:0]  gap_cnt_reg,  gap_cnt_next;
    logic [FILT_W-1:0] filt_cnt_reg, filt_cnt_next;
    logic [IDX_W-1:0]  idx_reg,      idx_next;
    logic [N_RST-1:0]  rst_out_reg,  rst_out_next;
    logic              all_rdy_reg,  all_rdy_next;
    logic [7:0]        loss_cnt_reg, loss_cnt_next;
    logic              lock_lost;
    logic              soft_abort;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg    <= WAIT_LOCK;
            hold_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            filt_cnt_reg <= '0;
            idx_reg      <= '0;
            rst_out_reg  <= '1;
            all_rdy_reg  <= 1'b0;
            loss_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            filt_cnt_reg <= filt_cnt_next;
            idx_reg      <= idx_next;
            rst_out_reg  <= rst_out_next;
            all_rdy_reg  <= all_rdy_next;
            loss_cnt_reg <= loss_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        filt_cnt_next = '0;
        idx_next      = idx_reg;
        rst_out_next  = rst_out_reg;
        all_rdy_next  = all_rdy_reg;
        loss_cnt_next = loss_cnt_reg;

        // Lock is only policed once domains start coming out of reset.
        lock_lost  = ((state_reg == RELEASE) || (state_reg == RUN)) &&
                     !lock_s && (filt_cnt_reg == FILT_LAST);
        soft_abort = soft_rst && (state_reg != WAIT_LOCK);

        if ((state_reg == RELEASE) || (state_reg == RUN)) begin
            filt_cnt_next = lock_s ? '0 : filt_cnt_reg + FILT_W'(1);
        end

        case (state_reg)
            WAIT_LOCK: begin
                rst_out_next = '1;
                all_rdy_next = 1'b0;
                if (lock_s) begin
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                end
            end
            HOLD: begin
                hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                if (!lock_s) begin
                    state_next    = WAIT_LOCK;
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next    = RELEASE;
                    hold_cnt_next = '0;
                    idx_next      = '0;
                    gap_cnt_next  = '0;
                end
            end
            RELEASE: begin
                if (gap_cnt_reg != GAP_LAST) begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end else if (!RDY_MASK[idx_reg] || rdy_s) begin
                    rst_out_next[idx_reg] = 1'b0;
                    gap_cnt_next          = '0;
                    idx_next              = idx_reg + IDX_W'(1);
                    if (idx_reg == IDX_LAST) begin
                        state_next   = RUN;
                        all_rdy_next = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase

        if (lock_lost || soft_abort) begin
            state_next    = WAIT_LOCK;
            rst_out_next  = '1;
            all_rdy_next  = 1'b0;
            hold_cnt_next = '0;
            gap_cnt_next  = '0;
            filt_cnt_next = '0;
            idx_next      = '0;
        end

        if (lock_lost && (loss_cnt_reg != 8'hFF)) begin
            loss_cnt_next = loss_cnt_reg + 8'd1;
        end
    end

    assign rst_out       = rst_out_reg;
    assign all_rdy       = all_rdy_reg;
    assign seq_state     = state_reg;
    assign lock_loss_cnt = loss_cnt_reg;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: edge-numbered stimulus with hand-computed
// expectations for power-up, ready gating, lock glitches, soft reset and saturation.
module tb_rst_sequencer;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       idelay_rdy = 1'b0;
    logic       soft_rst = 1'b0;
    logic [3:0] rst_out;
    logic       all_rdy;
    logic [1:0] seq_state;
    logic [7:0] lock_loss_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cur_edge = 0;

    rst_sequencer #(
        .N_RST      (4),
        .HOLD_CYCLES(8),
        .STAGE_GAP  (4),
        .LOCK_FILT  (3),
        .RDY_MASK   (4'b0100)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .pll_lock     (pll_lock),
        .idelay_rdy   (idelay_rdy),
        .soft_rst     (soft_rst),
        .rst_out      (rst_out),
        .all_rdy      (all_rdy),
        .seq_state    (seq_state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, cur_edge, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cur_edge++;
    endtask

    task automatic run_to(input int e);
        while (cur_edge < e) tick();
    endtask

    // Holds reset across two edges, checks the reset state, then releases it
    // 1 ns after the edge that becomes edge 0.
    task automatic do_reset();
        sys_rst_n  = 1'b0;
        pll_lock   = 1'b0;
        idelay_rdy = 1'b0;
        soft_rst   = 1'b0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        chk("rst_rst_out", rst_out, 4'b1111);
        chk("rst_all_rdy", all_rdy, 1'b0);
        chk("rst_state", seq_state, 2'd0);
        chk("rst_loss_cnt", lock_loss_cnt, 8'd0);
        sys_rst_n = 1'b1;
        cur_edge  = 0;
    endtask

    int ev_edge;
    int exp_cnt;

    initial begin
        // Power-up
        do_reset();
        pll_lock   = 1'b1;
        idelay_rdy = 1'b1;
        run_to(2);  chk("pu_wait", seq_state, 2'd0);
        run_to(3);  chk("pu_hold", seq_state, 2'd1);
        run_to(10); chk("pu_hold_end", seq_state, 2'd1);
        run_to(11); chk("pu_release", seq_state, 2'd2);
        run_to(14); chk("pu_rst14", rst_out, 4'b1111);
        run_to(15); chk("pu_rst15", rst_out, 4'b1110);
        run_to(18); chk("pu_rst18", rst_out, 4'b1110);
        run_to(19); chk("pu_rst19", rst_out, 4'b1100);
        run_to(23); chk("pu_rst23", rst_out, 4'b1000);
        run_to(26); chk("pu_rdy26", all_rdy, 1'b0);
        run_to(27); chk("pu_rst27", rst_out, 4'b0000);
        chk("pu_rdy27", all_rdy, 1'b1);
        chk("pu_run", seq_state, 2'd3);

        // 2-cycle lock glitch in RUN is filtered out
        run_to(30); pll_lock = 1'b0;
        run_to(32); pll_lock = 1'b1;
        run_to(35); chk("gl2_rst", rst_out, 4'b0000);
        run_to(40); chk("gl2_state", seq_state, 2'd3);
        chk("gl2_cnt", lock_loss_cnt, 8'd0);

        // 3-cycle glitch counts as loss of lock
        pll_lock = 1'b0;
        run_to(43); pll_lock = 1'b1;
        run_to(44); chk("gl3_rst44", rst_out, 4'b0000);
        run_to(45); chk("gl3_rst45", rst_out, 4'b1111);
        chk("gl3_cnt", lock_loss_cnt, 8'd1);
        chk("gl3_state", seq_state, 2'd0);
        chk("gl3_rdy", all_rdy, 1'b0);
        run_to(46); chk("rerun_hold", seq_state, 2'd1);
        run_to(54); chk("rerun_release", seq_state, 2'd2);
        run_to(58); chk("rerun_rst58", rst_out, 4'b1110);
        run_to(70); chk("rerun_rst70", rst_out, 4'b0000);
        chk("rerun_rdy70", all_rdy, 1'b1);

        // Losing idelay_rdy in RUN changes nothing
        idelay_rdy = 1'b0;
        run_to(75); chk("rdydrop_rst", rst_out, 4'b0000);
        chk("rdydrop_rdy", all_rdy, 1'b1);

        // Ready gating stalls domain 2 only
        do_reset();
        pll_lock = 1'b1;
        run_to(19); chk("rg_rst19", rst_out, 4'b1100);
        run_to(23); chk("rg_rst23", rst_out, 4'b1100);
        run_to(40); chk("rg_rst40", rst_out, 4'b1100);
        idelay_rdy = 1'b1;
        run_to(42); chk("rg_rst42", rst_out, 4'b1100);
        run_to(43); chk("rg_rst43", rst_out, 4'b1000);
        run_to(46); chk("rg_rdy46", all_rdy, 1'b0);
        run_to(47); chk("rg_rst47", rst_out, 4'b0000);
        chk("rg_rdy47", all_rdy, 1'b1);

        // Lock drop during HOLD aborts back to WAIT_LOCK without a loss event
        do_reset();
        pll_lock   = 1'b1;
        idelay_rdy = 1'b1;
        run_to(6);  pll_lock = 1'b0;
        run_to(7);  pll_lock = 1'b1;
        run_to(8);  chk("ha_hold8", seq_state, 2'd1);
        run_to(9);  chk("ha_wait9", seq_state, 2'd0);
        run_to(10); chk("ha_hold10", seq_state, 2'd1);
        run_to(17); chk("ha_hold17", seq_state, 2'd1);
        run_to(18); chk("ha_release18", seq_state, 2'd2);
        chk("ha_cnt", lock_loss_cnt, 8'd0);

        // Soft reset mid-RELEASE, then soft reset coinciding with filtered loss
        do_reset();
        pll_lock   = 1'b1;
        idelay_rdy = 1'b1;
        run_to(19); chk("sr_rst19", rst_out, 4'b1100);
        run_to(20); soft_rst = 1'b1;
        run_to(21); soft_rst = 1'b0;
        chk("sr_rst21", rst_out, 4'b1111);
        chk("sr_state21", seq_state, 2'd0);
        chk("sr_cnt21", lock_loss_cnt, 8'd0);
        run_to(22); chk("sr_hold22", seq_state, 2'd1);
        run_to(30); chk("sr_release30", seq_state, 2'd2);
        run_to(35); pll_lock = 1'b0;
        run_to(39); chk("both_rst39", rst_out, 4'b1100);
        soft_rst = 1'b1;
        run_to(40); soft_rst = 1'b0;
        pll_lock = 1'b1;
        chk("both_rst40", rst_out, 4'b1111);
        chk("both_cnt40", lock_loss_cnt, 8'd1);
        chk("both_state40", seq_state, 2'd0);
        run_to(42); chk("wl_wait42", seq_state, 2'd0);
        soft_rst = 1'b1;
        run_to(43); soft_rst = 1'b0;
        chk("wl_soft_ignored", seq_state, 2'd1);

        // Asynchronous reset between edges while in RELEASE
        run_to(53); chk("ar_release53", seq_state, 2'd2);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("ar_rst_out", rst_out, 4'b1111);
        chk("ar_all_rdy", all_rdy, 1'b0);
        chk("ar_state", seq_state, 2'd0);
        chk("ar_cnt", lock_loss_cnt, 8'd0);

        // 300 loss events: 4-cycle drop every 16 cycles, each caught in RELEASE
        do_reset();
        pll_lock   = 1'b1;
        idelay_rdy = 1'b1;
        ev_edge = 12;
        exp_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            run_to(ev_edge);     pll_lock = 1'b0;
            run_to(ev_edge + 4); pll_lock = 1'b1;
            run_to(ev_edge + 5);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            chk("sat_cnt", lock_loss_cnt, exp_cnt[7:0]);
            ev_edge += 16;
        end
        chk("sat_rst", rst_out, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
